// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: op encoding, entry layout and width constants.
package rob_pkg;
  localparam int IDX_W     = 5;
  localparam int XLEN      = 32;
  localparam int ROB_DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    OP_REG    = 2'd0,
    OP_STORE  = 2'd1,
    OP_BRANCH = 2'd2,
    OP_NOP    = 2'd3
  } rob_op_t;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  typedef struct packed {
    logic            ready;
    rob_op_t         op;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] addr;
    logic [2:0]      funct3;
    logic            mispred;
  } rob_entry_t;
endpackage

// File: rtl/rob_commit_unit_st_align.sv
// Store lane alignment: places store data in its byte lane and builds the byte mask.
module st_align
  import rob_pkg::*;
#(
  parameter int W = rob_pkg::XLEN
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr_lo,
  input  logic [W-1:0] data,
  output logic [3:0]   wmask,
  output logic [W-1:0] wdata
);
  always_comb begin
    wmask = 4'hF;
    wdata = data;
    case (funct3)
      F3_SB: begin
        wmask = 4'b0001 << addr_lo;
        wdata = W'(data[7:0]) << {addr_lo, 3'b000};
      end
      F3_SH: begin
        wmask = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = W'(data[15:0]) << {addr_lo[1], 4'b0000};
      end
      default: begin
        wmask = 4'hF;
        wdata = data;
      end
    endcase
  end
endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement of the reorder-queue head: regfile write, store via
// req/resp handshake, or mispredict flush with PC redirect.
module rob_commit_unit
  import rob_pkg::*;
#(
  parameter int IDX_W = rob_pkg::IDX_W,
  parameter int XLEN  = rob_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cir_q_empty,
  input  logic             head_ready,
  input  logic [IDX_W-1:0] head_idx,
  input  logic [1:0]       head_op,
  input  logic [4:0]       head_rd,
  input  logic [XLEN-1:0]  head_result,
  input  logic [XLEN-1:0]  head_addr,
  input  logic [2:0]       head_funct3,
  input  logic             head_mispred,
  output logic             commit,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_data,
  output logic [IDX_W-1:0] rf_rob_idx,
  output logic             dmem_write,
  output logic [XLEN-1:0]  dmem_address,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [3:0]       dmem_wmask,
  input  logic             dmem_resp,
  output logic             flush,
  output logic [XLEN-1:0]  pc_redirect,
  output logic [31:0]      retired_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_STORE, S_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] st_addr_q, st_addr_d, st_wdata_q, st_wdata_d;
  logic [3:0]      st_wmask_q, st_wmask_d;
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wmask;
  logic            head_valid;
  rob_op_t         op;

  assign op         = rob_op_t'(head_op);
  assign head_valid = !cir_q_empty && head_ready;

  st_align #(.W(XLEN)) u_st_align (
    .funct3  (head_funct3),
    .addr_lo (head_addr[1:0]),
    .data    (head_result),
    .wmask   (al_wmask),
    .wdata   (al_wdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_addr_d   = st_addr_q;
    st_wdata_d  = st_wdata_q;
    st_wmask_d  = st_wmask_q;
    commit      = 1'b0;
    rf_we       = 1'b0;
    rf_rd       = '0;
    rf_data     = '0;
    rf_rob_idx  = '0;
    flush       = 1'b0;
    pc_redirect = '0;
    dmem_write  = 1'b0;
    case (state_q)
      S_IDLE: if (head_valid) begin
        case (op)
          OP_REG, OP_NOP: begin
            commit = 1'b1;
            if (op == OP_REG) begin
              rf_we      = 1'b1;
              rf_rd      = head_rd;
              rf_data    = head_result;
              rf_rob_idx = head_idx;
            end
          end
          OP_STORE: begin
            st_addr_d  = {head_addr[XLEN-1:2], 2'b00};
            st_wdata_d = al_wdata;
            st_wmask_d = al_wmask;
            state_d    = S_STORE;
          end
          OP_BRANCH: begin
            commit = 1'b1;
            if (head_mispred) begin
              flush       = 1'b1;
              pc_redirect = head_addr;
              state_d     = S_FLUSH;
            end
          end
          default: ;
        endcase
      end
      S_STORE: begin
        // The store retires only once memory acknowledges it.
        if (dmem_resp) begin
          commit  = !cir_q_empty;
          state_d = S_IDLE;
        end else begin
          dmem_write = 1'b1;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      commit     = 1'b0;
      rf_we      = 1'b0;
      flush      = 1'b0;
      dmem_write = 1'b0;
    end
    if (commit) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      st_addr_q  <= '0;
      st_wdata_q <= '0;
      st_wmask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      st_addr_q  <= st_addr_d;
      st_wdata_q <= st_wdata_d;
      st_wmask_q <= st_wmask_d;
    end
  end

  assign dmem_address = st_addr_q;
  assign dmem_wdata   = st_wdata_q;
  assign dmem_wmask   = st_wmask_q;
  assign retired_cnt  = cnt_q;
endmodule
